// File: rtl/dm_ctrl_pkg.sv
// Shared definitions for the data-memory arbiter.
// Op codes, FSM states and the latched request bundle.
package dm_ctrl_pkg;

  localparam logic [2:0] DMOP_SW = 3'd0;
  localparam logic [2:0] DMOP_SB = 3'd1;
  localparam logic [2:0] DMOP_LW = 3'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    K_SW = 2'd0,
    K_SB = 2'd1,
    K_LD = 2'd2
  } kind_e;

  typedef struct packed {
    logic        id;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } txn_t;

  // Unknown op codes fall back to a load.
  function automatic kind_e op_kind(input logic [2:0] op);
    kind_e k;
    k = K_LD;
    unique case (1'b1)
      (op == DMOP_SW): k = K_SW;
      (op == DMOP_SB): k = K_SB;
      default:         k = K_LD;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/byte_merge.sv
// Replaces one byte lane of a word.
// Lane 0 is bits [7:0], lane 3 is bits [31:24].
module byte_merge (
  input  logic [31:0] word_i,
  input  logic [7:0]  byte_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] word_o
);

  // Select the lane to overwrite; other lanes pass through.
  always_comb begin
    word_o = word_i;
    unique case (lane_i)
      2'd0: word_o[7:0]   = byte_i;
      2'd1: word_o[15:8]  = byte_i;
      2'd2: word_o[23:16] = byte_i;
      2'd3: word_o[31:24] = byte_i;
      default: word_o = word_i;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of data memory.
// Byte stores become a read then a full-word write.
module dm_arbiter
  import dm_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        Reset_n,
  input  logic        P0_Req,
  input  logic [2:0]  P0_Op,
  input  logic [31:0] P0_Addr,
  input  logic [31:0] P0_WData,
  input  logic [31:0] P0_PC,
  output logic        P0_Ack,
  output logic [31:0] P0_RData,
  input  logic        P1_Req,
  input  logic [2:0]  P1_Op,
  input  logic [31:0] P1_Addr,
  input  logic [31:0] P1_WData,
  input  logic [31:0] P1_PC,
  output logic        P1_Ack,
  output logic [31:0] P1_RData,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic        MemWE,
  output logic [2:0]  MemDMOP,
  output logic [31:0] MemPC,
  input  logic [31:0] MemRData,
  output logic        Busy
);

  state_e      state_q, state_d;
  logic        last_q, last_d;
  txn_t        txn_q, txn_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rd0_q, rd0_d;
  logic [31:0] rd1_q, rd1_d;

  logic        win;
  kind_e       kind;
  logic [31:0] merged;
  logic        done;
  logic        ld_fwd;

  assign kind = op_kind(txn_q.op);

  byte_merge u_merge (
    .word_i (merge_q),
    .byte_i (txn_q.wdata[7:0]),
    .lane_i (txn_q.addr[1:0]),
    .word_o (merged)
  );

  // Registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      txn_q   <= '0;
      merge_q <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      txn_q   <= txn_d;
      merge_q <= merge_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  // Grant, sequencing and capture of read data.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    txn_d   = txn_q;
    merge_d = merge_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    win     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (P0_Req || P1_Req) begin
          win = (P0_Req && P1_Req) ? ~last_q : P1_Req;
          last_d = win;
          if (win) begin
            txn_d = '{1'b1, P1_Op, P1_Addr,
                      P1_WData, P1_PC};
          end else begin
            txn_d = '{1'b0, P0_Op, P0_Addr,
                      P0_WData, P0_PC};
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        unique case (kind)
          K_SB: begin
            merge_d = MemRData;
            state_d = MERGE;
          end
          K_SW: state_d = IDLE;
          default: begin
            if (txn_q.id) rd1_d = MemRData;
            else          rd0_d = MemRData;
            state_d = IDLE;
          end
        endcase
      end
      MERGE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore decode of the memory strobes and completion.
  always_comb begin
    MemWE    = 1'b0;
    MemWData = '0;
    done     = 1'b0;
    ld_fwd   = 1'b0;
    unique case (state_q)
      ACCESS: begin
        unique case (kind)
          K_SW: begin
            MemWE    = 1'b1;
            MemWData = txn_q.wdata;
            done     = 1'b1;
          end
          K_SB: done = 1'b0;
          default: begin
            done   = 1'b1;
            ld_fwd = 1'b1;
          end
        endcase
      end
      MERGE: begin
        MemWE    = 1'b1;
        MemWData = merged;
        done     = 1'b1;
      end
      default: done = 1'b0;
    endcase
  end

  assign P0_Ack  = done & ~txn_q.id;
  assign P1_Ack  = done &  txn_q.id;

  // Load data is forwarded in the Ack cycle and held afterwards.
  assign P0_RData = (ld_fwd && !txn_q.id) ? MemRData : rd0_q;
  assign P1_RData = (ld_fwd &&  txn_q.id) ? MemRData : rd1_q;

  assign MemAddr = txn_q.addr;
  assign MemPC   = txn_q.pc;
  assign MemDMOP = DMOP_SW;
  assign Busy    = (state_q != IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter.
// Directed table, corner sequences and random traffic.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        P0_Req = 0, P1_Req = 0;
  logic [2:0]  P0_Op = 0, P1_Op = 0;
  logic [31:0] P0_Addr = 0, P1_Addr = 0;
  logic [31:0] P0_WData = 0, P1_WData = 0;
  logic [31:0] P0_PC = 0, P1_PC = 0;
  logic        P0_Ack, P1_Ack;
  logic [31:0] P0_RData, P1_RData;
  logic [31:0] MemAddr, MemWData, MemPC, MemRData;
  logic        MemWE, Busy;
  logic [2:0]  MemDMOP;

  dm_arbiter dut (
    .clk(clk), .Reset_n(Reset_n),
    .P0_Req(P0_Req), .P0_Op(P0_Op),
    .P0_Addr(P0_Addr), .P0_WData(P0_WData),
    .P0_PC(P0_PC), .P0_Ack(P0_Ack),
    .P0_RData(P0_RData),
    .P1_Req(P1_Req), .P1_Op(P1_Op),
    .P1_Addr(P1_Addr), .P1_WData(P1_WData),
    .P1_PC(P1_PC), .P1_Ack(P1_Ack),
    .P1_RData(P1_RData),
    .MemAddr(MemAddr), .MemWData(MemWData),
    .MemWE(MemWE), .MemDMOP(MemDMOP),
    .MemPC(MemPC), .MemRData(MemRData),
    .Busy(Busy)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, clocked word write.
  logic [31:0] dm [0:8191];
  logic        pl_en = 1'b0;
  logic [12:0] pl_idx = '0;
  logic [31:0] pl_val = '0;
  assign MemRData = dm[MemAddr[14:2]];
  always @(posedge clk) begin
    if (pl_en) dm[pl_idx] <= pl_val;
    else if (MemWE) dm[MemAddr[14:2]] <= MemWData;
  end

  // Reference: word array updated per transaction.
  logic [31:0] ref_mem [0:8191];
  logic [31:0] exp_rd0 = 0, exp_rd1 = 0;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h",
               nm, act, exp);
    end
  endtask

  task automatic preload(input int idx,
                         input logic [31:0] v);
    pl_en  = 1'b1;
    pl_idx = idx[12:0];
    pl_val = v;
    ref_mem[idx] = v;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic drive(input int p, input logic on,
                       input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] w,
                       input logic [31:0] pcv);
    if (p == 0) begin
      P0_Req = on; P0_Op = op; P0_Addr = a;
      P0_WData = w; P0_PC = pcv;
    end else begin
      P1_Req = on; P1_Op = op; P1_Addr = a;
      P1_WData = w; P1_PC = pcv;
    end
  endtask

  task automatic ref_apply(input logic [2:0] op,
                           input logic [31:0] addr,
                           input logic [31:0] wd,
                           output logic [31:0] erd,
                           output int elat,
                           output int ewe,
                           output logic [31:0] ewd);
    int w;
    int sh;
    w = int'(addr[14:2]);
    sh = 8 * int'(addr[1:0]);
    erd = 0;
    ewd = 0;
    if (op == 3'd0) begin
      elat = 1; ewe = 1; ewd = wd;
      ref_mem[w] = wd;
    end else if (op == 3'd1) begin
      elat = 2; ewe = 1;
      ewd = (ref_mem[w] & ~(32'hFF << sh))
          | ({24'b0, wd[7:0]} << sh);
      ref_mem[w] = ewd;
    end else begin
      elat = 1; ewe = 0;
      erd = ref_mem[w];
    end
  endtask

  // One transaction from an IDLE negedge; ends at IDLE negedge.
  task automatic do_txn(input string tag, input int p,
                        input logic [2:0] op,
                        input logic [31:0] addr,
                        input logic [31:0] wd,
                        input logic [31:0] xrd,
                        input int xlat, input int xwe,
                        input logic [31:0] xwd);
    int lat, wes, c;
    logic [31:0] rd, wdat, waddr, mpc, pcv;
    logic me, other;
    pcv = $urandom;
    lat = 0; wes = 0; rd = 0;
    wdat = 0; waddr = 0; mpc = 0;
    drive(p, 1'b1, op, addr, wd, pcv);
    c = 0;
    while (lat == 0 && c < 8) begin
      c++;
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_busy"}, {31'b0, Busy}, 32'd1);
      if (MemWE) begin
        wes++; wdat = MemWData; waddr = MemAddr;
      end
      me    = (p == 0) ? P0_Ack : P1_Ack;
      other = (p == 0) ? P1_Ack : P0_Ack;
      chk({tag, "_other_ack"}, {31'b0, other}, 0);
      if (me) begin
        lat = c;
        rd  = (p == 0) ? P0_RData : P1_RData;
        mpc = MemPC;
        chk({tag, "_dmop"}, {29'b0, MemDMOP}, 0);
      end
    end
    @(posedge clk);
    #1 drive(p, 1'b0, op, addr, wd, pcv);
    @(negedge clk);
    chk({tag, "_lat"}, lat, xlat);
    chk({tag, "_we_cycles"}, wes, xwe);
    chk({tag, "_pc"}, mpc, pcv);
    if (xwe > 0) begin
      chk({tag, "_wdata"}, wdat, xwd);
      chk({tag, "_waddr"}, waddr, addr);
    end else begin
      chk({tag, "_rdata"}, rd, xrd);
      if (p == 0) exp_rd0 = xrd;
      else        exp_rd1 = xrd;
    end
    chk({tag, "_ack_pulse"},
        {30'b0, P0_Ack, P1_Ack}, 0);
    chk({tag, "_idle"}, {31'b0, Busy}, 0);
    chk({tag, "_rd0_hold"}, P0_RData, exp_rd0);
    chk({tag, "_rd1_hold"}, P1_RData, exp_rd1);
  endtask

  typedef struct {
    int          p;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          lat;
    int          we;
    logic [31:0] xwd;
  } vec_t;

  vec_t tbl [12];

  task automatic reset_outputs(input string tag);
    chk({tag, "_ack"}, {30'b0, P0_Ack, P1_Ack}, 0);
    chk({tag, "_we"}, {31'b0, MemWE}, 0);
    chk({tag, "_busy"}, {31'b0, Busy}, 0);
    chk({tag, "_addr"}, MemAddr, 0);
    chk({tag, "_wdata"}, MemWData, 0);
    chk({tag, "_pc"}, MemPC, 0);
    chk({tag, "_dmop"}, {29'b0, MemDMOP}, 0);
    chk({tag, "_rd0"}, P0_RData, 0);
    chk({tag, "_rd1"}, P1_RData, 0);
  endtask

  initial begin
    logic [31:0] erd, ewd;
    int elat, ewe, r, p;
    logic [2:0] op;
    logic [31:0] a, w;
    int ack_cyc [6];
    int ack_port [6];
    int na, cyc;

    tbl[0]  = '{0, 3'd2, 32'h04, 0, 32'h12345678, 1, 0, 0};
    tbl[1]  = '{0, 3'd0, 32'h10, 32'hDEADBEEF, 0, 1, 1,
                32'hDEADBEEF};
    tbl[2]  = '{0, 3'd2, 32'h10, 0, 32'hDEADBEEF, 1, 0, 0};
    tbl[3]  = '{0, 3'd1, 32'h21, 32'h11, 0, 2, 1,
                32'hAABB11DD};
    tbl[4]  = '{0, 3'd1, 32'h23, 32'hFFFFFF11, 0, 2, 1,
                32'h11BB11DD};
    tbl[5]  = '{1, 3'd2, 32'h20, 0, 32'h11BB11DD, 1, 0, 0};
    tbl[6]  = '{1, 3'd0, 32'h13, 32'hCAFEF00D, 0, 1, 1,
                32'hCAFEF00D};
    tbl[7]  = '{1, 3'd2, 32'h11, 0, 32'hCAFEF00D, 1, 0, 0};
    tbl[8]  = '{1, 3'd7, 32'h04, 0, 32'h12345678, 1, 0, 0};
    tbl[9]  = '{0, 3'd1, 32'h18, 32'hAB, 0, 2, 1,
                32'h000000AB};
    tbl[10] = '{1, 3'd1, 32'h1A, 32'hCD, 0, 2, 1,
                32'h00CD00AB};
    tbl[11] = '{0, 3'd2, 32'h18, 0, 32'h00CD00AB, 1, 0, 0};

    // Preload memory while reset is held.
    for (int i = 0; i < 128; i++) preload(i, $urandom);
    preload(1, 32'h12345678);
    preload(6, 32'h0);
    preload(8, 32'hAABBCCDD);
    preload(12, 32'h01020304);
    preload(16, 32'h0A0B0C0D);
    @(negedge clk);
    reset_outputs("reset");
    Reset_n = 1'b1;
    @(negedge clk);
    reset_outputs("post_reset");

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      ref_apply(tbl[i].op, tbl[i].addr, tbl[i].wd,
                erd, elat, ewe, ewd);
      do_txn($sformatf("vec%0d", i), tbl[i].p,
             tbl[i].op, tbl[i].addr, tbl[i].wd,
             tbl[i].rd, tbl[i].lat, tbl[i].we,
             tbl[i].xwd);
    end

    // P1 byte store in MERGE while P0 request rises.
    ref_apply(3'd1, 32'h32, 32'h55, erd, elat, ewe, ewd);
    drive(1, 1'b1, 3'd1, 32'h32, 32'h55, 32'h100);
    @(posedge clk);
    @(negedge clk);
    chk("sb_access_no_we", {31'b0, MemWE}, 0);
    chk("sb_access_no_ack", {30'b0, P0_Ack, P1_Ack}, 0);
    @(posedge clk);
    #1 drive(0, 1'b1, 3'd2, 32'h30, 0, 32'h200);
    @(negedge clk);
    chk("sb_merge_ack", {30'b0, P0_Ack, P1_Ack}, 32'd1);
    chk("sb_merge_we", {31'b0, MemWE}, 32'd1);
    chk("sb_merge_wdata", MemWData, 32'h01550304);
    chk("sb_merge_model", MemWData, ewd);
    @(posedge clk);
    #1 drive(1, 1'b0, 3'd1, 32'h32, 32'h55, 32'h100);
    @(negedge clk);
    chk("p0_wait_idle", {30'b0, P0_Ack, P1_Ack}, 0);
    @(posedge clk);
    @(negedge clk);
    ref_apply(3'd2, 32'h30, 0, erd, elat, ewe, ewd);
    chk("p0_after_sb_ack", {30'b0, P0_Ack, P1_Ack}, 32'd2);
    chk("p0_after_sb_rd", P0_RData, erd);
    exp_rd0 = erd;
    @(posedge clk);
    #1 drive(0, 1'b0, 3'd2, 32'h30, 0, 32'h200);
    @(negedge clk);

    // Reset during MERGE abandons the byte store.
    drive(0, 1'b1, 3'd1, 32'h40, 32'hFF, 32'h300);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_merge_we_before", {31'b0, MemWE}, 32'd1);
    Reset_n = 1'b0;
    #1;
    reset_outputs("rst_merge");
    drive(0, 1'b0, 3'd1, 32'h40, 32'hFF, 32'h300);
    @(posedge clk);
    @(negedge clk);
    chk("rst_merge_mem", dm[16], ref_mem[16]);
    chk("rst_merge_mem_k", dm[16], 32'h0A0B0C0D);
    Reset_n = 1'b1;
    exp_rd0 = 0;
    exp_rd1 = 0;
    @(negedge clk);

    // Both ports hold loads from reset: strict alternation.
    drive(0, 1'b1, 3'd2, 32'h04, 0, 32'h400);
    drive(1, 1'b1, 3'd2, 32'h20, 0, 32'h500);
    na = 0;
    cyc = 0;
    while (na < 6 && cyc < 40) begin
      cyc++;
      @(posedge clk);
      @(negedge clk);
      if (P0_Ack && P1_Ack) chk("rr_both_ack",
        {30'b0, P0_Ack, P1_Ack}, 32'd2);
      if (P0_Ack || P1_Ack) begin
        ack_cyc[na] = cyc;
        ack_port[na] = P1_Ack ? 1 : 0;
        na++;
      end
    end
    @(posedge clk);
    #1;
    drive(0, 1'b0, 3'd2, 32'h04, 0, 32'h400);
    drive(1, 1'b0, 3'd2, 32'h20, 0, 32'h500);
    @(negedge clk);
    chk("rr_count", na, 6);
    for (int i = 0; i < na; i++) begin
      chk($sformatf("rr_port%0d", i), ack_port[i], i % 2);
      if (i > 0)
        chk($sformatf("rr_gap%0d", i),
            ack_cyc[i] - ack_cyc[i-1], 2);
    end
    exp_rd0 = ref_mem[1];
    exp_rd1 = ref_mem[8];
    chk("rr_rd0", P0_RData, exp_rd0);
    chk("rr_rd1", P1_RData, exp_rd1);

    // Random single-port traffic against the reference.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 5);
      if (r < 3) op = r[2:0];
      else op = 3'($urandom_range(3, 7));
      p = $urandom_range(0, 1);
      a = 32'h100 + $urandom_range(0, 255);
      w = $urandom;
      ref_apply(op, a, w, erd, elat, ewe, ewd);
      do_txn($sformatf("rnd%0d", i), p, op, a, w,
             erd, elat, ewe, ewd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
